// File: rtl/ldst_pipe_arbiter_if.sv
// ldst_pipe_arbiter_if: requester, memory-stage and completion signals of the
// data-memory load/store port arbiter. "slave" is the arbiter's view, "master"
// is the view of the requesters plus memory stage that surround it.
interface ldst_pipe_arbiter_if #(
    parameter int unsigned PAYLOAD_W = 122,
    parameter int unsigned DATA_W    = 32
);
    // Port 0: execute-stage load/store unit
    logic                 iP0_REQ;
    logic [PAYLOAD_W-1:0] iP0_PAYLOAD;
    logic                 oP0_BUSY;
    logic                 oP0_VALID;
    logic [DATA_W-1:0]    oP0_DATA;

    // Port 1: debug / DMA access unit
    logic                 iP1_REQ;
    logic [PAYLOAD_W-1:0] iP1_PAYLOAD;
    logic                 oP1_BUSY;
    logic                 oP1_VALID;
    logic [DATA_W-1:0]    oP1_DATA;

    // Memory access stage
    logic                 oMEM_REQ;
    logic [PAYLOAD_W-1:0] oMEM_PAYLOAD;
    logic                 iMEM_BUSY;
    logic                 iMEM_VALID;
    logic [DATA_W-1:0]    iMEM_DATA;

    modport slave (
        input  iP0_REQ, iP0_PAYLOAD,
        output oP0_BUSY, oP0_VALID, oP0_DATA,
        input  iP1_REQ, iP1_PAYLOAD,
        output oP1_BUSY, oP1_VALID, oP1_DATA,
        output oMEM_REQ, oMEM_PAYLOAD,
        input  iMEM_BUSY, iMEM_VALID, iMEM_DATA
    );

    modport master (
        output iP0_REQ, iP0_PAYLOAD,
        input  oP0_BUSY, oP0_VALID, oP0_DATA,
        output iP1_REQ, iP1_PAYLOAD,
        input  oP1_BUSY, oP1_VALID, oP1_DATA,
        input  oMEM_REQ, oMEM_PAYLOAD,
        output iMEM_BUSY, iMEM_VALID, iMEM_DATA
    );
endinterface

// File: rtl/ldst_pipe_arbiter.sv
// ldst_pipe_arbiter: two-requester arbiter for the single data-memory
// load/store port. Port 0 is the execute-stage LSU, port 1 a debug/DMA master.
// One transaction outstanding at a time; request payload is forwarded
// combinationally (zero added latency) and the completion is routed back to
// the owning requester only.
//
// Build option: define LDST_ARB_ROUND_ROBIN_EN to alternate ties between the
// ports; otherwise port 0 always wins a tie.
//
// Payload layout (MSB..LSB), forwarded bit-exact:
//   RW[121] PDT[120:89] ADDR[88:57] DATA[56:25] ORDER[24:23] MASK[22:19]
//   ASID[18:5] MMUMOD[4:3] MMUPS[2:0]
module ldst_pipe_arbiter #(
    parameter int unsigned PAYLOAD_W = 122
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iRESET_SYNC,
    input  logic              iEVENT_HOLD,
    ldst_pipe_arbiter_if.slave bus
);

    localparam int unsigned DATA_W = 32;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       owner_q;
    logic       owner_d;
`ifdef LDST_ARB_ROUND_ROBIN_EN
    logic       last_grant_q;
    logic       last_grant_d;
`endif

    logic       hold_c;
    logic       idle_c;
    logic       pri0_c;
    logic       pri1_c;
    logic       win0_c;
    logic       win1_c;
    logic       done_c;

    // Reset, synchronous reset and pipeline flush all suppress grants and
    // completions in the current cycle and return the FSM to IDLE.
    assign hold_c = !inRESET || iRESET_SYNC || iEVENT_HOLD;
    assign idle_c = (state_q == ST_IDLE);

    // Tie-break: which port may win when both request in the same cycle
`ifdef LDST_ARB_ROUND_ROBIN_EN
    assign pri0_c = !bus.iP1_REQ || last_grant_q;
    assign pri1_c = !bus.iP0_REQ || !last_grant_q;
`else
    assign pri0_c = 1'b1;
    assign pri1_c = !bus.iP0_REQ;
`endif

    // Grant qualification: only in IDLE, with the memory stage ready and no flush
    assign win0_c = idle_c && !hold_c && !bus.iMEM_BUSY && bus.iP0_REQ && pri0_c;
    assign win1_c = idle_c && !hold_c && !bus.iMEM_BUSY && bus.iP1_REQ && pri1_c;

    // Completion of the outstanding transaction; a stray VALID in IDLE is ignored
    assign done_c = (state_q == ST_WAIT) && bus.iMEM_VALID && !hold_c;

    // Next-state logic and the combinational handshake outputs
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
`ifdef LDST_ARB_ROUND_ROBIN_EN
        last_grant_d     = last_grant_q;
`endif
        bus.oMEM_REQ     = 1'b0;
        bus.oMEM_PAYLOAD = bus.iP0_PAYLOAD;
        bus.oP0_VALID    = 1'b0;
        bus.oP1_VALID    = 1'b0;
        bus.oP0_DATA     = '0;
        bus.oP1_DATA     = '0;
        bus.oP0_BUSY     = !idle_c || bus.iMEM_BUSY || win1_c || hold_c;
        bus.oP1_BUSY     = !idle_c || bus.iMEM_BUSY || win0_c || hold_c;

        bus.oMEM_REQ = win0_c || win1_c;
        if (!inRESET) begin
            bus.oMEM_PAYLOAD = '0;
        end else if (win1_c) begin
            bus.oMEM_PAYLOAD = bus.iP1_PAYLOAD;
        end

        if (done_c) begin
            bus.oP0_VALID = !owner_q;
            bus.oP1_VALID = owner_q;
            if (owner_q) begin
                bus.oP1_DATA = bus.iMEM_DATA;
            end else begin
                bus.oP0_DATA = bus.iMEM_DATA;
            end
        end

        if (hold_c) begin
            state_d      = ST_IDLE;
            owner_d      = 1'b0;
`ifdef LDST_ARB_ROUND_ROBIN_EN
            last_grant_d = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win0_c || win1_c) begin
                        state_d      = ST_WAIT;
                        owner_d      = win1_c;
`ifdef LDST_ARB_ROUND_ROBIN_EN
                        last_grant_d = win1_c;
`endif
                    end
                end
                ST_WAIT: begin
                    if (done_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, owner and tie-break history registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
`ifdef LDST_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
`ifdef LDST_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Never two winners in one cycle
    a_single_winner: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        !(win0_c && win1_c));

    // Completions only leave the arbiter while a transaction is outstanding
    a_valid_in_wait: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        (bus.oP0_VALID || bus.oP1_VALID) |-> (state_q == ST_WAIT));

    // At most one requester sees its completion per cycle
    a_valid_onehot: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        !(bus.oP0_VALID && bus.oP1_VALID));

    // Read data is zero whenever the matching completion strobe is low
    a_data_zero: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        (!bus.oP0_VALID -> (bus.oP0_DATA == DATA_W'(0))) &&
        (!bus.oP1_VALID -> (bus.oP1_DATA == DATA_W'(0))));

    // A granted request is never marked busy to its own requester
    a_grant_not_busy: assert property (@(posedge iCLOCK) disable iff (!inRESET)
        (win0_c -> !bus.oP0_BUSY) && (win1_c -> !bus.oP1_BUSY));

endmodule

// File: tb/tb_ldst_pipe_arbiter.sv
// tb_ldst_pipe_arbiter: randomized requesters and memory stage drive the
// arbiter; a transaction-level model predicts grants, completions and BUSY,
// pushing expectations into queues that a negedge monitor pops and compares.
module tb_ldst_pipe_arbiter;

    localparam int unsigned PW = 122;
    localparam int unsigned NCYC = 4000;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } cpl_t;

    typedef struct packed {
        logic chk;
        logic b0;
        logic b1;
    } cyc_t;

    logic iCLOCK = 1'b0;
    logic inRESET;
    logic iRESET_SYNC;
    logic iEVENT_HOLD;

    always #5 iCLOCK = ~iCLOCK;

    ldst_pipe_arbiter_if bus ();

    ldst_pipe_arbiter dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iEVENT_HOLD (iEVENT_HOLD),
        .bus         (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [PW-1:0] gq [$];
    cpl_t          cq [$];
    cyc_t          yq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or completion
    initial begin
        forever begin
            @(negedge iCLOCK);
            if (bus.oMEM_REQ) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 128'(bus.oMEM_REQ), 128'(0));
                end else begin
                    check("grant_payload", 128'(bus.oMEM_PAYLOAD), 128'(gq.pop_front()));
                end
            end
            if (bus.oP0_VALID || bus.oP1_VALID) begin
                if (cq.size() == 0) begin
                    check("cpl_unexpected", 128'({bus.oP1_VALID, bus.oP0_VALID}), 128'(0));
                end else begin
                    cpl_t c;
                    c = cq.pop_front();
                    check("cpl_port", 128'({bus.oP1_VALID, bus.oP0_VALID}),
                          c.port ? 128'(2'b10) : 128'(2'b01));
                    check("cpl_data", c.port ? 128'(bus.oP1_DATA) : 128'(bus.oP0_DATA),
                          128'(c.data));
                end
            end
            if (!bus.oP0_VALID) check("p0_data_zero", 128'(bus.oP0_DATA), 128'(0));
            if (!bus.oP1_VALID) check("p1_data_zero", 128'(bus.oP1_DATA), 128'(0));
            if (yq.size() != 0) begin
                cyc_t y;
                y = yq.pop_front();
                if (y.chk) begin
                    check("p0_busy", 128'(bus.oP0_BUSY), 128'(y.b0));
                    check("p1_busy", 128'(bus.oP1_BUSY), 128'(y.b1));
                end
            end
            check("grant_missed", 128'(gq.size()), 128'(0));
            check("cpl_missed", 128'(cq.size()), 128'(0));
        end
    end

    // Model state: one outstanding transaction, owner, and who wins the next tie
    bit            outstanding;
    int            owner;
    int            tie_winner;
    bit            pend [2];
    logic [PW-1:0] pay  [2];
    bit            mem_pend;
    int            mem_lat;
    int            n_async;

    task automatic model_reset();
        outstanding = 1'b0;
        owner       = 0;
        tie_winner  = 0;
    endtask

    // Driver: randomized requesters and memory stage, model predicts responses
    initial begin
        logic [127:0] r;
        bit           membusy;
        bit           memvalid;
        logic [31:0]  memdata;
        bit           flush;
        int           w;

        inRESET         = 1'b0;
        iRESET_SYNC     = 1'b0;
        iEVENT_HOLD     = 1'b0;
        bus.iP0_REQ     = 1'b0;
        bus.iP1_REQ     = 1'b0;
        bus.iP0_PAYLOAD = '0;
        bus.iP1_PAYLOAD = '0;
        bus.iMEM_BUSY   = 1'b0;
        bus.iMEM_VALID  = 1'b0;
        bus.iMEM_DATA   = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        mem_pend = 1'b0;
        mem_lat  = 0;
        n_async  = 0;
        model_reset();

        repeat (3) @(posedge iCLOCK);
        #1;
        check("rst_mem_req", 128'(bus.oMEM_REQ), 128'(0));
        check("rst_p0_valid", 128'(bus.oP0_VALID), 128'(0));
        check("rst_p1_valid", 128'(bus.oP1_VALID), 128'(0));
        inRESET = 1'b1;

        for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
            @(posedge iCLOCK);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    r = {$urandom(), $urandom(), $urandom(), $urandom()};
                    pend[p] = 1'b1;
                    pay[p]  = r[PW-1:0];
                end
            end
            membusy  = ($urandom_range(0, 4) == 0);
            memvalid = 1'b0;
            if (mem_pend) begin
                if (mem_lat <= 1) begin
                    memvalid = 1'b1;
                    mem_pend = 1'b0;
                end else begin
                    mem_lat--;
                end
            end else if (!outstanding) begin
                memvalid = ($urandom_range(0, 15) == 0);
            end
            memdata = $urandom();
            flush   = ($urandom_range(0, 29) == 0);

            bus.iP0_REQ     = pend[0];
            bus.iP1_REQ     = pend[1];
            bus.iP0_PAYLOAD = pay[0];
            bus.iP1_PAYLOAD = pay[1];
            bus.iMEM_BUSY   = membusy;
            bus.iMEM_VALID  = memvalid;
            bus.iMEM_DATA   = memdata;
            iRESET_SYNC     = flush && $urandom_range(0, 1) == 0;
            iEVENT_HOLD     = flush && !iRESET_SYNC;

            if (outstanding && !flush && n_async < 4 && cyc > 400 * (n_async + 1)) begin
                // Async reset while a transaction is outstanding
                n_async++;
                bus.iMEM_VALID = 1'b1;
                #1 inRESET = 1'b0;
                #1;
                check("async_mem_req", 128'(bus.oMEM_REQ), 128'(0));
                check("async_p0_valid", 128'(bus.oP0_VALID), 128'(0));
                check("async_p1_valid", 128'(bus.oP1_VALID), 128'(0));
                check("async_p0_data", 128'(bus.oP0_DATA), 128'(0));
                check("async_p1_data", 128'(bus.oP1_DATA), 128'(0));
                @(posedge iCLOCK);
                #1;
                bus.iP0_REQ    = 1'b0;
                bus.iP1_REQ    = 1'b0;
                bus.iMEM_BUSY  = 1'b0;
                bus.iMEM_VALID = 1'b0;
                pend[0]        = 1'b1;
                r = {$urandom(), $urandom(), $urandom(), $urandom()};
                pay[0]         = r[PW-1:0];
                inRESET        = 1'b1;
                model_reset();
                continue;
            end

            if (flush) begin
                yq.push_back('{chk: 1'b0, b0: 1'b0, b1: 1'b0});
                model_reset();
            end else if (outstanding) begin
                yq.push_back('{chk: 1'b1, b0: 1'b1, b1: 1'b1});
                if (memvalid) begin
                    cq.push_back('{port: (owner == 1), data: memdata});
                    outstanding = 1'b0;
                end
            end else begin
                w = -1;
                if (!membusy) begin
                    if (pend[0] && pend[1]) w = tie_winner;
                    else if (pend[0])       w = 0;
                    else if (pend[1])       w = 1;
                end
                yq.push_back('{chk: 1'b1, b0: membusy || (w == 1), b1: membusy || (w == 0)});
                if (w >= 0) begin
                    gq.push_back(pay[w]);
                    outstanding = 1'b1;
                    owner       = w;
                    pend[w]     = 1'b0;
                    mem_pend    = 1'b1;
                    mem_lat     = $urandom_range(1, 4);
`ifdef LDST_ARB_ROUND_ROBIN_EN
                    tie_winner  = 1 - w;
`endif
                end
            end
        end

        @(negedge iCLOCK);
        #1;
        check("end_grant_queue", 128'(gq.size()), 128'(0));
        check("end_cpl_queue", 128'(cq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
